// File: rtl/register_file_2w2r.sv
// Architectural register file: two write ports from writeback, two registered
// read ports with write-through, and a per-register pending-write scoreboard.
module register_file_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        write,
  input  logic [DATA_W-1:0] wr1,
  input  logic [DATA_W-1:0] wr2,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [ADDR_W-1:0] wa2,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              lock,
  input  logic [ADDR_W-1:0] la,
  output logic              busy1,
  output logic              busy2
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] rd2_d;

  logic [NREG-1:0]   hit1;
  logic [NREG-1:0]   hit2;
  logic [NREG-1:0]   lock_hit;

  // Per-register decode; a hard-wired zero register never sees a hit.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_dec
      localparam logic [ADDR_W-1:0] IDX     = ADDR_W'(gi);
      localparam bit                IS_ZERO = (ZERO_REG != 0) && (gi == 0);
      assign hit1[gi]     = !IS_ZERO && write[0] && (wa1 == IDX);
      assign hit2[gi]     = !IS_ZERO && write[1] && (wa2 == IDX);
      assign lock_hit[gi] = !IS_ZERO && lock && (la == IDX);
    end
  endgenerate

  // Port 2 wins a same-address collision; a same-cycle lock outranks the clear.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i]    = regs_q[i];
      pending_d[i] = pending_q[i];
      if (hit2[i]) begin
        regs_d[i] = wr2;
      end else if (hit1[i]) begin
        regs_d[i] = wr1;
      end
      if (lock_hit[i]) begin
        pending_d[i] = 1'b1;
      end else if (hit1[i] || hit2[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // Reading the next-state array gives write-through for free.
  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (re) begin
      rd1_d = regs_d[ra1];
      rd2_d = regs_d[ra2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q <= pending_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
    end
  end

  assign rd1   = rd1_q;
  assign rd2   = rd2_q;
  assign busy1 = pending_q[ra1];
  assign busy2 = pending_q[ra2];

endmodule

// File: tb/tb_register_file_2w2r.sv
// Directed bench for register_file_2w2r: a plain build and a zero-register
// build driven by the same stimulus.
module tb_register_file_2w2r;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  write;
  logic [31:0] wr1, wr2;
  logic [4:0]  wa1, wa2;
  logic        re;
  logic [4:0]  ra1, ra2;
  logic        lock;
  logic [4:0]  la;
  logic [31:0] rd1, rd2, rd1_z, rd2_z;
  logic        busy1, busy2, busy1_z, busy2_z;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  register_file_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .write(write), .wr1(wr1), .wr2(wr2),
    .wa1(wa1), .wa2(wa2), .re(re), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .lock(lock), .la(la),
    .busy1(busy1), .busy2(busy2)
  );

  register_file_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .write(write), .wr1(wr1), .wr2(wr2),
    .wa1(wa1), .wa2(wa2), .re(re), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_z), .rd2(rd2_z), .lock(lock), .la(la),
    .busy1(busy1_z), .busy2(busy2_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 2'b00;
    lock  = 1'b0;
    re    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; write = 2'b11; wa1 = 5'd1; wa2 = 5'd2;
    wr1 = 32'hFFFF_FFFF; wr2 = 32'h1234_5678; lock = 1'b1; la = 5'd3;
    re = 1'b1; ra1 = 5'd1; ra2 = 5'd2;
    tick();
    tick();
    n_checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) $display("FAIL reset_rd got=%h/%h exp=0/0", rd1, rd2);
    else n_pass++;
    rst = 1'b1;
    idle();
    for (int a = 0; a < 32; a++) begin
      re = 1'b1; ra1 = 5'(a); ra2 = 5'(31 - a);
      tick();
      n_checks++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0 || busy1 !== 1'b0 || busy2 !== 1'b0)
        $display("FAIL reset_scan a=%0d got rd=%h/%h busy=%b%b exp rd=0/0 busy=00",
                 a, rd1, rd2, busy1, busy2);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_single_write();
    write = 2'b01; wa1 = 5'd5; wr1 = 32'hDEAD_BEEF;
    tick();
    idle(); re = 1'b1; ra1 = 5'd5; ra2 = 5'd6;
    tick();
    n_checks++;
    if (rd1 !== 32'hDEAD_BEEF) $display("FAIL single_rd1 got=%h exp=deadbeef", rd1);
    else n_pass++;
    n_checks++;
    if (rd2 !== 32'h0) $display("FAIL single_rd2 got=%h exp=0", rd2);
    else n_pass++;
    re = 1'b0; ra1 = 5'd0;
    tick();
    n_checks++;
    if (rd1 !== 32'hDEAD_BEEF) $display("FAIL hold_re0 got=%h exp=deadbeef", rd1);
    else n_pass++;
  endtask

  task automatic test_dual_write();
    write = 2'b11; wa1 = 5'd7; wa2 = 5'd7; wr1 = 32'd1; wr2 = 32'd2;
    tick();
    wa1 = 5'd3; wr1 = 32'hA; wa2 = 5'd4; wr2 = 32'hB;
    tick();
    write = 2'b10; wa1 = 5'd21; wr1 = 32'h88; wa2 = 5'd20; wr2 = 32'h77;
    tick();
    idle(); re = 1'b1; ra1 = 5'd7; ra2 = 5'd3;
    tick();
    n_checks++;
    if (rd1 !== 32'd2) $display("FAIL collision_r7 got=%h exp=2", rd1);
    else n_pass++;
    n_checks++;
    if (rd2 !== 32'hA) $display("FAIL dual_r3 got=%h exp=a", rd2);
    else n_pass++;
    ra1 = 5'd4; ra2 = 5'd20;
    tick();
    n_checks++;
    if (rd1 !== 32'hB) $display("FAIL dual_r4 got=%h exp=b", rd1);
    else n_pass++;
    n_checks++;
    if (rd2 !== 32'h77) $display("FAIL port2_only_r20 got=%h exp=77", rd2);
    else n_pass++;
    ra1 = 5'd21;
    tick();
    n_checks++;
    if (rd1 !== 32'h0) $display("FAIL port2_only_r21 got=%h exp=0", rd1);
    else n_pass++;
    idle();
  endtask

  task automatic test_write_through();
    write = 2'b01; wa1 = 5'd9; wr1 = 32'h55; re = 1'b1; ra1 = 5'd9; ra2 = 5'd9;
    tick();
    n_checks++;
    if (rd1 !== 32'h55 || rd2 !== 32'h55) $display("FAIL wt_r9 got=%h/%h exp=55/55", rd1, rd2);
    else n_pass++;
    write = 2'b11; wa1 = 5'd10; wa2 = 5'd10; wr1 = 32'h1; wr2 = 32'h2;
    ra1 = 5'd10; ra2 = 5'd10;
    tick();
    n_checks++;
    if (rd1 !== 32'h2 || rd2 !== 32'h2) $display("FAIL wt_collision got=%h/%h exp=2/2", rd1, rd2);
    else n_pass++;
    idle();
  endtask

  task automatic test_scoreboard();
    lock = 1'b1; la = 5'd12; ra1 = 5'd12; ra2 = 5'd13;
    #1;
    n_checks++;
    if (busy1 !== 1'b0) $display("FAIL lock_not_forwarded got=%b exp=0", busy1);
    else n_pass++;
    tick();
    lock = 1'b0;
    #1;
    n_checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b0) $display("FAIL lock_set got=%b%b exp=10", busy1, busy2);
    else n_pass++;
    write = 2'b10; wa2 = 5'd12; wr2 = 32'hC0DE;
    #1;
    n_checks++;
    if (busy1 !== 1'b1) $display("FAIL clear_not_forwarded got=%b exp=1", busy1);
    else n_pass++;
    tick();
    write = 2'b00;
    #1;
    n_checks++;
    if (busy1 !== 1'b0) $display("FAIL write_clear got=%b exp=0", busy1);
    else n_pass++;
    lock = 1'b1; la = 5'd12; write = 2'b01; wa1 = 5'd12; wr1 = 32'hF00D;
    tick();
    idle();
    #1;
    n_checks++;
    if (busy1 !== 1'b1) $display("FAIL lock_beats_write got=%b exp=1", busy1);
    else n_pass++;
    write = 2'b01; wa1 = 5'd12; wr1 = 32'h0;
    tick();
    idle();
    #1;
    n_checks++;
    if (busy1 !== 1'b0) $display("FAIL reclear got=%b exp=0", busy1);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    write = 2'b11; wa1 = 5'd0; wr1 = 32'hFF; wa2 = 5'd1; wr2 = 32'h11;
    lock = 1'b1; la = 5'd0;
    tick();
    idle(); re = 1'b1; ra1 = 5'd0; ra2 = 5'd1;
    tick();
    n_checks++;
    if (rd1_z !== 32'h0 || rd2_z !== 32'h11) $display("FAIL zero_read got=%h/%h exp=0/11", rd1_z, rd2_z);
    else n_pass++;
    n_checks++;
    if (busy1_z !== 1'b0) $display("FAIL zero_busy got=%b exp=0", busy1_z);
    else n_pass++;
    n_checks++;
    if (rd1 !== 32'hFF || busy1 !== 1'b1) $display("FAIL plain_r0 got=%h/%b exp=ff/1", rd1, busy1);
    else n_pass++;
    write = 2'b01; wa1 = 5'd0; wr1 = 32'hABCD; re = 1'b1; ra1 = 5'd0;
    tick();
    n_checks++;
    if (rd1_z !== 32'h0 || rd1 !== 32'hABCD) $display("FAIL zero_wt got=%h/%h exp=0/abcd", rd1_z, rd1);
    else n_pass++;
    idle();
  endtask

  initial begin
    rst = 1'b0; write = 2'b00; wr1 = '0; wr2 = '0; wa1 = '0; wa2 = '0;
    re = 1'b0; ra1 = '0; ra2 = '0; lock = 1'b0; la = '0;
    test_reset();
    test_single_write();
    test_dual_write();
    test_write_through();
    test_scoreboard();
    test_zero_reg();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
